// File: rtl/lockstep_pkg.sv
// Shared types and constants for the dual-core lockstep write controller.
package lockstep_pkg;

    localparam int LS_ADDR_W = 5;
    localparam int LS_DATA_W = 32;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        ROLLBACK  = 2'd1,
        WAIT_DONE = 2'd2,
        FATAL     = 2'd3
    } state_e;

    typedef struct packed {
        logic                 we;
        logic [LS_ADDR_W-1:0] addr;
        logic [LS_DATA_W-1:0] data;
    } wr_port_t;

endpackage

// File: rtl/lockstep_ctrl_cmp.sv
// Field-wise equality of the two cores' write ports; error_o is raw and
// must be qualified by the caller with a valid sample.
module lockstep_ctrl_cmp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic                  error_o
);

    assign error_o = (we_a_i != we_b_i) || (addr_a_i != addr_b_i) || (data_a_i != data_b_i);

endmodule

// File: rtl/lockstep_ctrl.sv
// Lockstep write controller: commits matching core writes, rolls back on divergence.
// Optional mismatch counter enabled by defining LOCKSTEP_ERR_CNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | compare/commit core writes, stall low
// ROLLBACK  | single-cycle rollback pulse to both cores, stalled
// WAIT_DONE | stalled until cores report checkpoint restored
// FATAL     | retries exhausted; stalled until reset or clear_i
module lockstep_ctrl
    import lockstep_pkg::*;
#(
    parameter int ADDR_WIDTH = LS_ADDR_W,
    parameter int DATA_WIDTH = LS_DATA_W,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  stall_o,
    output logic                  rollback_o,
    input  logic                  rollback_done_i,
    input  logic                  clear_i,
    output logic                  fatal_o,
    output logic [ERR_CNT_W-1:0]  err_count_o
);

    localparam int                 RETRY_W     = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [RETRY_W-1:0]  r_retry;
    logic [RETRY_W-1:0]  w_retry_nxt;
    logic [RETRY_W-1:0]  w_retry_inc;
    logic                w_cmp_err;
    logic                w_sample;
    logic                w_match;
    logic                w_mismatch;

    logic                  r_rf_we;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  r_stall;
    logic                  r_rollback;
    logic                  r_fatal;

    lockstep_ctrl_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .we_a_i   (we_a_i),
        .we_b_i   (we_b_i),
        .addr_a_i (addr_a_i),
        .addr_b_i (addr_b_i),
        .data_a_i (data_a_i),
        .data_b_i (data_b_i),
        .error_o  (w_cmp_err)
    );

    assign w_sample    = (r_state == RUN) && (we_a_i || we_b_i);
    assign w_match     = w_sample && !w_cmp_err;
    assign w_mismatch  = w_sample && w_cmp_err;
    assign w_retry_inc = r_retry + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        case (r_state)
            RUN: begin
                if (w_match) begin
                    w_retry_nxt = '0;
                end else if (w_mismatch) begin
                    w_retry_nxt = w_retry_inc;
                    w_state_nxt = (w_retry_inc < RETRY_LIMIT) ? ROLLBACK : FATAL;
                end
            end
            ROLLBACK: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rollback_done_i) begin
                    w_state_nxt = RUN;
                end
            end
            FATAL: begin
                if (clear_i) begin
                    w_state_nxt = RUN;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_retry_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change only on the clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retry    <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_stall    <= 1'b0;
            r_rollback <= 1'b0;
            r_fatal    <= 1'b0;
        end else begin
            r_retry    <= w_retry_nxt;
            r_rf_we    <= w_match;
            if (w_match) begin
                r_rf_addr  <= addr_a_i;
                r_rf_wdata <= data_a_i;
            end
            r_stall    <= (w_state_nxt != RUN);
            r_rollback <= (w_state_nxt == ROLLBACK);
            r_fatal    <= (w_state_nxt == FATAL);
        end
    end

    assign rf_we_o    = r_rf_we;
    assign rf_addr_o  = r_rf_addr;
    assign rf_wdata_o = r_rf_wdata;
    assign stall_o    = r_stall;
    assign rollback_o = r_rollback;
    assign fatal_o    = r_fatal;

`ifdef LOCKSTEP_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (w_mismatch && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_count_o = r_err_cnt;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: doc/lockstep_ctrl.md
LOCKSTEP_CTRL -- requirements
Module: lockstep_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 5, register-file address width.
- DATA_WIDTH, default 32, write-data width.
- MAX_RETRY, default 3, mismatches tolerated before FATAL.
REQ-002 Ports SHALL be as listed below:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- we_a_i / we_b_i  in  1  write enable from core A / core B.
- addr_a_i / addr_b_i  in  ADDR_WIDTH  write address from core A / core B.
- data_a_i / data_b_i  in  DATA_WIDTH  write data from core A / core B.
- rf_we_o  out  1  committed write enable to the shared register file.
- rf_addr_o  out  ADDR_WIDTH  committed address.
- rf_wdata_o  out  DATA_WIDTH  committed data.
- stall_o  out  1  halts both cores.
- rollback_o  out  1  one-cycle rollback request to both cores.
- rollback_done_i  in  1  cores restored to checkpoint.
- clear_i  in  1  synchronous release from FATAL.
- fatal_o  out  1  unrecoverable divergence.
- err_count_o  out  8  saturating mismatch count.

Function
REQ-003 The FSM SHALL have exactly four states: RUN, ROLLBACK, WAIT_DONE, FATAL.
REQ-004 Sampling rule: in RUN, a write port pair with (we_a_i | we_b_i)=1 in cycle t SHALL be compared.
- Match: all of we, addr, data equal.
- If both enables are 0, no comparison SHALL occur.
REQ-005 On match in cycle t, rf_we_o SHALL be 1 in cycle t+1 with rf_addr_o/rf_wdata_o = the core A values; latency is fixed at one cycle, back-to-back every cycle.
REQ-006 On mismatch in cycle t, rf_we_o SHALL stay 0 (no commit) and the retry counter SHALL increment.
- If the new retry value < MAX_RETRY: go to ROLLBACK.
- Otherwise: go to FATAL.
REQ-007 ROLLBACK SHALL last exactly one cycle with rollback_o=1 and stall_o=1, then go to WAIT_DONE.
REQ-008 WAIT_DONE SHALL hold stall_o=1 until rollback_done_i=1, then return to RUN in the next cycle.
- rollback_done_i is ignored in every other state.
REQ-009 Core ports SHALL be ignored (no compare, no commit) in ROLLBACK, WAIT_DONE and FATAL.
REQ-010 The retry counter SHALL clear to 0 on the first matching commit in RUN.
REQ-011 In FATAL, stall_o=1 and fatal_o=1, and the state SHALL be left only by reset or clear_i=1.
- clear_i=1 goes to RUN and clears the retry counter.
- clear_i has no effect outside FATAL.
REQ-012 stall_o SHALL be 0 in RUN, including the cycle a mismatch is sampled; it rises in cycle t+1.
REQ-013 rf_we_o, rollback_o and fatal_o SHALL be glitch-free registered outputs.

Reset
REQ-014 While rst_ni=0, all state SHALL be reset asynchronously:
- FSM to RUN; retry counter and err_count_o to 0.
- rf_we_o=0, rf_addr_o=0, rf_wdata_o=0, stall_o=0, rollback_o=0, fatal_o=0.
REQ-015 Reset asserted mid-ROLLBACK or mid-WAIT_DONE SHALL abort the sequence; the first post-reset cycle is RUN.

Configuration
REQ-016 With macro LOCKSTEP_ERR_CNT_EN defined:
- err_count_o SHALL increment on every mismatch and saturate at 255.
- It SHALL be cleared only by reset, never by clear_i.
REQ-017 Without LOCKSTEP_ERR_CNT_EN, err_count_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-018 Package lockstep_pkg SHALL hold:
- the FSM state enum typedef;
- a write-port struct typedef (we, addr, data) parameterised via the package widths;
- the ERR_CNT_W=8 constant.
REQ-019 Field equality SHALL be computed by one instance of the existing comparator sub-module; its error_o is used only when a sample is valid.

Verification
REQ-020 Match commit: A=B={we=1, addr=5, data=0xDEADBEEF} in cycle 10 -> rf_we_o=1, rf_addr_o=5, rf_wdata_o=0xDEADBEEF in cycle 11; stall_o=0 throughout.
REQ-021 Single mismatch: data_a=0x1, data_b=0x3, addr=7, we=1 in cycle 10 ->
- no commit;
- rollback_o=1 and stall_o=1 in cycle 11;
- stall_o held until rollback_done_i is pulsed in cycle 15;
- RUN in cycle 16; err_count_o=1 (macro on).
REQ-022 Retry exhaustion: three consecutive mismatch episodes with no intervening match (MAX_RETRY=3) -> the third mismatch enters FATAL (fatal_o=1, stall_o=1); clear_i=1 -> RUN next cycle, fatal_o=0.
REQ-023 Enable divergence and idle: we_a=1, we_b=0, equal addr/data -> mismatch path taken; we_a=we_b=0 with differing addr -> no action.
REQ-024 Retry clear and reset abort:
- Mismatch, rollback, then a match -> retry counter back to 0, so three further mismatches are needed for FATAL.
- rst_ni=0 during WAIT_DONE -> all outputs 0 and state RUN.
